// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit framer: parity modes, FSM encoding
// and the parity helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Payload is zero-extended to 9 bits, which leaves its XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic x;
        x = ^data;
        if (mode == PAR_ODD) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    // Free-running bit-period counter, held at zero while the framer idles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear || (cnt_r == LAST)) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: frames a captured payload as start, data (LSB first),
// optional parity and stop bits on a registered, idle-high serial line.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 out,
    output logic                 sgn,
    output logic                 tx_done
);

    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_framer: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_framer: CLKS_PER_BIT must be at least 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx_framer: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end

    state_t                state_r;
    logic                  out_r;
    logic                  par_r;
    logic [DATA_BITS-1:0]  shift_r;
    logic [3:0]            bit_cnt_r;
    logic                  tick_s;
    logic                  clear_s;
    logic                  last_data_s;
    logic                  last_stop_s;

    assign clear_s     = (state_r == ST_IDLE);
    assign last_data_s = (bit_cnt_r == 4'(DATA_BITS - 1));
    assign last_stop_s = (bit_cnt_r == 4'(STOP_BITS - 1));

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear_s),
        .tick (tick_s)
    );

    // Frame sequencer; out_r changes on the same edge as the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            out_r     <= 1'b1;
            par_r     <= 1'b0;
            shift_r   <= {DATA_BITS{1'b0}};
            bit_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_r     <= 1'b1;
                    bit_cnt_r <= 4'd0;
                    if (tx_valid) begin
                        state_r <= ST_START;
                        out_r   <= 1'b0;
                        shift_r <= tx_data;
                        par_r   <= parity_bit(9'(tx_data), PARITY);
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        state_r <= ST_DATA;
                        out_r   <= shift_r[0];
                        shift_r <= shift_r >> 1;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (!last_data_s) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            out_r     <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                        end else if (PARITY != PAR_NONE) begin
                            state_r   <= ST_PAR;
                            bit_cnt_r <= 4'd0;
                            out_r     <= par_r;
                        end else begin
                            state_r   <= ST_STOP;
                            bit_cnt_r <= 4'd0;
                            out_r     <= 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (tick_s) begin
                        state_r   <= ST_STOP;
                        bit_cnt_r <= 4'd0;
                        out_r     <= 1'b1;
                    end
                end
                ST_STOP: begin
                    out_r <= 1'b1;
                    if (tick_s) begin
                        if (last_stop_s) begin
                            state_r   <= ST_IDLE;
                            bit_cnt_r <= 4'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_r     <= 1'b1;
                    bit_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign tx_ready = (state_r == ST_IDLE);
    assign sgn      = (state_r != ST_IDLE);
    assign out      = out_r;
    // Decoded from registers only: high during the final cycle of the last stop bit.
    assign tx_done  = (state_r == ST_STOP) && tick_s && last_stop_s;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench: four framer configurations, hand-computed bit patterns
// compared cycle by cycle against the serial line.
module tb_uart_tx_framer;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid_a [4];
    logic [7:0] data_a     [4];
    logic       ready_a    [4];
    logic       out_a      [4];
    logic       sgn_a      [4];
    logic       done_a     [4];

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst_n), .tx_valid(tx_valid_a[0]), .tx_data(data_a[0]),
        .tx_ready(ready_a[0]), .out(out_a[0]), .sgn(sgn_a[0]), .tx_done(done_a[0]));
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst_n), .tx_valid(tx_valid_a[1]), .tx_data(data_a[1]),
        .tx_ready(ready_a[1]), .out(out_a[1]), .sgn(sgn_a[1]), .tx_done(done_a[1]));
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst_n), .tx_valid(tx_valid_a[2]), .tx_data(data_a[2]),
        .tx_ready(ready_a[2]), .out(out_a[2]), .sgn(sgn_a[2]), .tx_done(done_a[2]));
    uart_tx_framer #(.DATA_BITS(7), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst_n), .tx_valid(tx_valid_a[3]), .tx_data(data_a[3][6:0]),
        .tx_ready(ready_a[3]), .out(out_a[3]), .sgn(sgn_a[3]), .tx_done(done_a[3]));

    // bits[i] is the line level during bit period i (bit 0 = start bit)
    typedef struct {
        int          inst;
        int          nbits;
        logic [15:0] bits;
        int          gap;
    } frame_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    frame_t exp_q [$];
    chk_t   chk_q [$];
    int     checks = 0;
    int     errors = 0;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_frame(input int k, input int nb, input logic [15:0] bits, input int gap);
        frame_t f;
        f.inst  = k;
        f.nbits = nb;
        f.bits  = bits;
        f.gap   = gap;
        exp_q.push_back(f);
    endtask

    // Monitor: records each busy period and checks it against the scoreboard.
    initial begin : monitor
        int          ncyc    [4];
        logic [63:0] obs     [4];
        int          ndone   [4];
        int          done_at [4];
        int          idle    [4];
        int          gap_seen[4];
        frame_t      f;
        chk_t        c;
        logic [63:0] expv;
        logic [63:0] mask;
        for (int k = 0; k < 4; k++) begin
            ncyc[k] = 0; obs[k] = 64'd0; ndone[k] = 0; done_at[k] = -1;
            idle[k] = 1000; gap_seen[k] = 0;
        end
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                compare(c.name, c.act, c.exp);
            end
            for (int k = 0; k < 4; k++) begin
                if (!rst_n) begin
                    ncyc[k] = 0; obs[k] = 64'd0; ndone[k] = 0; done_at[k] = -1; idle[k] = 1000;
                end else if (sgn_a[k]) begin
                    if (ncyc[k] == 0) gap_seen[k] = idle[k];
                    if (ncyc[k] < 64) obs[k][ncyc[k]] = out_a[k];
                    if (done_a[k]) begin
                        ndone[k]++;
                        done_at[k] = ncyc[k];
                    end
                    ncyc[k]++;
                end else begin
                    compare($sformatf("u%0d_idle_lines", k), {62'd0, out_a[k], done_a[k]}, 64'd2);
                    if (ncyc[k] != 0) begin
                        if (exp_q.size() == 0) begin
                            compare($sformatf("u%0d_unexpected_frame", k), 64'd1, 64'd0);
                        end else begin
                            f = exp_q.pop_front();
                            expv = 64'd0;
                            mask = 64'd0;
                            for (int i = 0; i < f.nbits * C && i < 64; i++) begin
                                expv[i] = f.bits[i / C];
                                mask[i] = 1'b1;
                            end
                            compare($sformatf("u%0d_frame_inst", k), 64'(k), 64'(f.inst));
                            compare($sformatf("u%0d_busy_cycles", k), 64'(ncyc[k]), 64'(f.nbits * C));
                            compare($sformatf("u%0d_line_bits", k), obs[k] & mask, expv);
                            compare($sformatf("u%0d_done_pulses", k), 64'(ndone[k]), 64'd1);
                            compare($sformatf("u%0d_done_on_last", k), 64'(done_at[k]), 64'(ncyc[k] - 1));
                            if (f.gap >= 0) begin
                                compare($sformatf("u%0d_idle_gap", k), 64'(gap_seen[k]), 64'(f.gap));
                            end
                        end
                        ncyc[k] = 0; obs[k] = 64'd0; ndone[k] = 0; done_at[k] = -1; idle[k] = 0;
                    end
                    idle[k]++;
                end
            end
        end
    end

    // Called at a negedge with tx_valid already high; returns at the negedge after acceptance.
    task automatic wait_accept(input int k);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            acc = ready_a[k];
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!acc) push_chk($sformatf("u%0d_accept_timeout", k), 64'd0, 64'd1);
    endtask

    task automatic send(input int k, input logic [7:0] d);
        @(negedge clk);
        tx_valid_a[k] = 1'b1;
        data_a[k]     = d;
        wait_accept(k);
        tx_valid_a[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (sgn_a[k] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) push_chk($sformatf("u%0d_idle_timeout", k), 64'd0, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : stimulus
        int n;
        for (int k = 0; k < 4; k++) begin
            tx_valid_a[k] = 1'b0;
            data_a[k]     = 8'h00;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            push_chk($sformatf("u%0d_reset_state", k),
                     {60'd0, out_a[k], sgn_a[k], ready_a[k], done_a[k]}, 64'hA);
        end
        #1 rst_n = 1'b1;

        // Plain 8N1 frame
        expect_frame(0, 10, 16'b1101001010, -1);
        send(0, 8'hA5);
        wait_idle(0);

        // Parity variants
        expect_frame(1, 11, 16'b10101001010, -1);
        send(1, 8'hA5);
        wait_idle(1);
        expect_frame(2, 11, 16'b11101001010, -1);
        send(2, 8'hA5);
        wait_idle(2);
        expect_frame(1, 11, 16'b11000001110, -1);
        send(1, 8'h07);
        wait_idle(1);

        // 7 data bits, 2 stop bits
        expect_frame(3, 10, 16'b1110000010, -1);
        send(3, 8'h41);
        wait_idle(3);

        // tx_valid held: two frames with one idle cycle, data changed mid-frame
        expect_frame(0, 10, 16'b1010101010, -1);
        expect_frame(0, 10, 16'b1000011110, 1);
        @(negedge clk);
        tx_valid_a[0] = 1'b1;
        data_a[0]     = 8'h55;
        wait_accept(0);
        data_a[0] = 8'h0F;
        wait_accept(0);
        data_a[0]     = 8'hFF;
        tx_valid_a[0] = 1'b0;
        wait_idle(0);

        // Request raised in the tx_done cycle waits for the IDLE cycle
        expect_frame(0, 10, 16'b1101001010, -1);
        expect_frame(0, 10, 16'b1110000110, 1);
        send(0, 8'hA5);
        n = 0;
        while (!done_a[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        push_chk("u0_done_seen", {63'd0, done_a[0]}, 64'd1);
        push_chk("u0_ready_in_done_cycle", {63'd0, ready_a[0]}, 64'd0);
        tx_valid_a[0] = 1'b1;
        data_a[0]     = 8'hC3;
        @(negedge clk);
        push_chk("u0_idle_after_done", {62'd0, ready_a[0], sgn_a[0]}, 64'd2);
        wait_accept(0);
        tx_valid_a[0] = 1'b0;
        push_chk("u0_busy_after_accept", {63'd0, sgn_a[0]}, 64'd1);
        wait_idle(0);

        // Reset in the middle of data bit 3 (a 0 bit of 8'hA5)
        send(0, 8'hA5);
        repeat (17) @(negedge clk);
        push_chk("u0_in_data_bit3", {62'd0, out_a[0], sgn_a[0]}, 64'd1);
        #1 rst_n = 1'b0;
        #1 push_chk("u0_reset_midframe", {60'd0, out_a[0], sgn_a[0], ready_a[0], done_a[0]}, 64'hA);
        @(negedge clk);
        #1 rst_n = 1'b1;
        expect_frame(0, 10, 16'b1001111000, -1);
        send(0, 8'h3C);
        wait_idle(0);

        repeat (5) @(negedge clk);
        push_chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal minimum 2.
REQ-003 Parameter PARITY, default 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 tx_valid  input  1  a frame request is present on tx_data.
REQ-008 tx_data  input  DATA_BITS  payload to transmit.
REQ-009 tx_ready  output  1  block can accept a request this cycle.
REQ-010 out  output  1  serial line, idle high, registered.
REQ-011 sgn  output  1  busy: high from the start bit through the last stop bit.
REQ-012 tx_done  output  1  one-cycle pulse on completion of the last stop bit.

Function
REQ-013 The FSM states shall be IDLE, START, DATA, PAR, STOP; PAR shall be skipped when PARITY = 0.
REQ-014 tx_ready shall equal (state == IDLE).
REQ-015 A request is accepted on a cycle where tx_valid && tx_ready; tx_data is captured on that edge.
REQ-016 out shall go low (start bit) on the cycle after acceptance.
REQ-017 Each bit, including start, parity and each stop bit, shall hold for exactly CLKS_PER_BIT cycles, timed by a counter 0..CLKS_PER_BIT-1 that wraps to 0 at each bit boundary.
REQ-018 Data bits shall be sent LSB first from the captured copy; changes on tx_data or tx_valid while sgn = 1 shall have no effect.
REQ-019 The parity bit shall be the XOR of the captured data for even parity, and its inverse for odd parity.
REQ-020 STOP shall drive out = 1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done shall pulse on the final cycle of STOP, and the FSM shall then enter IDLE.
REQ-021 IDLE shall last at least one cycle, so back-to-back start-bit spacing is CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS)+1 cycles, where P = 1 if parity is enabled, else 0.
REQ-022 sgn shall be 1 in every non-IDLE state; out shall be 1 in IDLE.
REQ-023 Any parameter outside its legal range shall stop elaboration with an error.

Reset
REQ-024 Reset asserted, including mid-frame, shall force immediately: state IDLE, out = 1, sgn = 0, tx_ready = 1, tx_done = 0, bit counter 0, baud counter 0.
REQ-025 The first request after deassertion shall be accepted no earlier than the first rising clk edge with rst high.

Structure
REQ-026 Package uart_pkg shall hold the parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state encoding.
REQ-027 The baud counter shall be sub-module uart_baud_tick (parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick).
REQ-028 All outputs shall be driven directly from registers or from state decode; there shall be no combinational path from inputs to outputs.

Verification
REQ-029 Defaults except CLKS_PER_BIT = 4; send 8'hA5 -> out = 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles; tx_done pulses once; sgn is high for 40 cycles.
REQ-030 PARITY = 2 with 8'hA5 -> parity bit 0; PARITY = 1 with 8'hA5 -> parity bit 1; PARITY = 2 with 8'h07 -> parity bit 1.
REQ-031 STOP_BITS = 2, DATA_BITS = 7, send 7'h41 -> 7 data bits LSB first, then out high for 2*CLKS_PER_BIT cycles before tx_done.
REQ-032 tx_valid held high with two words 8'h55 then 8'h0F -> both frames sent in order, with exactly one IDLE cycle between them; tx_data changes mid-frame do not alter the bits sent.
REQ-033 rst pulsed low during DATA bit 3 -> out = 1, sgn = 0, tx_ready = 1 immediately; the next request after release sends a complete, correct frame.
REQ-034 tx_valid asserted in the same cycle as tx_done -> request not accepted until the following IDLE cycle.
